// File: rtl/dpram_arb_pkg.sv
// Shared types for the dual-port RAM arbiter: FSM states and the per-port
// read-return tag carried alongside each RAM command.
package dpram_arb_pkg;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  // Sized for the largest supported NUM_REQ (8). Smaller configs leave the top bits at 0.
  localparam int IDX_W = 3;

  typedef struct packed {
    logic             vld;
    logic             rd;
    logic [IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-winner round-robin picker. Slot A takes the first valid requester from ptr.
// Slot B takes the next valid requester that does not write-collide with A.
module rr_pick2
  import dpram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         valid,
  input  logic [IDX_W-1:0]           ptr,
  input  logic [NUM_REQ*NUM_REQ-1:0] conflict,
  output logic                       a_vld,
  output logic [IDX_W-1:0]           a_idx,
  output logic                       b_vld,
  output logic [IDX_W-1:0]           b_idx
);

  // conflict[x*NUM_REQ+y] is set when requesters x and y both write the same address.
  always_comb begin
    int i;
    int a;
    a_vld = 1'b0;
    b_vld = 1'b0;
    b_idx = '0;
    a     = 0;
    i     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      i = (int'(ptr) + k) % NUM_REQ;
      if (valid[i]) begin
        if (!a_vld) begin
          a_vld = 1'b1;
          a     = i;
        end else if (!b_vld && !conflict[a*NUM_REQ + i]) begin
          b_vld = 1'b1;
          b_idx = IDX_W'(i);
        end
      end
    end
    a_idx = IDX_W'(a);
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Shares both ports of a dual-port RAM among NUM_REQ requesters.
// The RAM is cleared after reset, and then up to two requests are granted per cycle in round-robin order.
module dpram_port_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [NUM_REQ*DATA_W-1:0] rsp_rdata,
  output logic                      init_done,
  output logic [ADDR_W-1:0]         ram_addr_a,
  output logic [ADDR_W-1:0]         ram_addr_b,
  output logic [DATA_W-1:0]         ram_wdata_a,
  output logic [DATA_W-1:0]         ram_wdata_b,
  output logic                      ram_we_a,
  output logic                      ram_we_b,
  input  logic [DATA_W-1:0]         ram_rdata_a,
  input  logic [DATA_W-1:0]         ram_rdata_b
);

  logic [NUM_REQ-1:0][ADDR_W-1:0] addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0][DATA_W-1:0] rdata_q;

  assign addr      = req_addr;
  assign wdata     = req_wdata;
  assign rsp_rdata = rdata_q;

  state_t            state, state_nx;
  logic [ADDR_W-2:0] cnt;
  logic [IDX_W-1:0]  ptr, ptr_nx;
  logic              run;

  assign run = (state == ST_RUN);

  logic [NUM_REQ*NUM_REQ-1:0] conflict;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ci
    for (genvar j = 0; j < NUM_REQ; j++) begin : g_cj
      assign conflict[i*NUM_REQ + j] = (i != j) && req_we[i] && req_we[j] && (addr[i] == addr[j]);
    end
  end

  logic             a_vld, b_vld;
  logic [IDX_W-1:0] a_idx, b_idx;

  rr_pick2 #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid    (run ? req_valid : '0),
    .ptr      (ptr),
    .conflict (conflict),
    .a_vld    (a_vld),
    .a_idx    (a_idx),
    .b_vld    (b_vld),
    .b_idx    (b_idx)
  );

  always_comb begin
    state_nx = state;
    if (state == ST_INIT && (&cnt)) state_nx = ST_RUN;
  end

  logic              a_we, b_we;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_wd, b_wd;

  always_comb begin
    req_ready = '0;
    a_we = 1'b0; a_addr = '0; a_wd = '0;
    b_we = 1'b0; b_addr = '0; b_wd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (a_vld && int'(a_idx) == i) begin
        req_ready[i] = 1'b1;
        a_we = req_we[i]; a_addr = addr[i]; a_wd = wdata[i];
      end
      if (b_vld && int'(b_idx) == i) begin
        req_ready[i] = 1'b1;
        b_we = req_we[i]; b_addr = addr[i]; b_wd = wdata[i];
      end
    end
    // Slot B is always later than slot A in scan order, so when B is used it is the last grant.
    ptr_nx = ptr;
    if (b_vld)      ptr_nx = (int'(b_idx) == NUM_REQ-1) ? '0 : b_idx + 1'b1;
    else if (a_vld) ptr_nx = (int'(a_idx) == NUM_REQ-1) ? '0 : a_idx + 1'b1;
  end

  tag_t tag0_a, tag0_b, tag1_a, tag1_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_INIT;
      cnt         <= '0;
      ptr         <= '0;
      init_done   <= 1'b0;
      ram_we_a    <= 1'b0;
      ram_we_b    <= 1'b0;
      ram_addr_a  <= '0;
      ram_addr_b  <= '0;
      ram_wdata_a <= '0;
      ram_wdata_b <= '0;
      tag0_a      <= '0;
      tag0_b      <= '0;
      tag1_a      <= '0;
      tag1_b      <= '0;
      rsp_valid   <= '0;
      rdata_q     <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      if (state == ST_INIT) begin
        // Both ports clear one even/odd pair per cycle.
        cnt         <= cnt + 1'b1;
        init_done   <= &cnt;
        ram_we_a    <= 1'b1;
        ram_we_b    <= 1'b1;
        ram_addr_a  <= {cnt, 1'b0};
        ram_addr_b  <= {cnt, 1'b1};
        ram_wdata_a <= '0;
        ram_wdata_b <= '0;
      end else begin
        ram_we_a <= a_vld & a_we;
        ram_we_b <= b_vld & b_we;
        if (a_vld) begin
          ram_addr_a  <= a_addr;
          ram_wdata_a <= a_wd;
        end
        if (b_vld) begin
          ram_addr_b  <= b_addr;
          ram_wdata_b <= b_wd;
        end
      end

      tag0_a <= '{vld: a_vld, rd: a_vld & ~a_we, idx: a_idx};
      tag0_b <= '{vld: b_vld, rd: b_vld & ~b_we, idx: b_idx};
      tag1_a <= tag0_a;
      tag1_b <= tag0_b;

      // A requester is granted at most once per cycle, so at most one port matches it.
      for (int i = 0; i < NUM_REQ; i++) begin
        rsp_valid[i] <= 1'b0;
        if (tag1_a.vld && tag1_a.rd && int'(tag1_a.idx) == i) begin
          rsp_valid[i] <= 1'b1;
          rdata_q[i]   <= ram_rdata_a;
        end else if (tag1_b.vld && tag1_b.rd && int'(tag1_b.idx) == i) begin
          rsp_valid[i] <= 1'b1;
          rdata_q[i]   <= ram_rdata_b;
        end
      end
    end
  end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter: a behavioural dual-port RAM plus a reference model built from
// a grant list, a memory image and a queue of expected read returns.
module tb_dpram_port_arbiter;
  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata, rsp_rdata;
  logic            init_done;
  logic [AW-1:0]   ram_addr_a, ram_addr_b;
  logic [DW-1:0]   ram_wdata_a, ram_wdata_b, ram_rdata_a, ram_rdata_b;
  logic            ram_we_a, ram_we_b;

  dpram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done),
    .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
    .ram_wdata_a(ram_wdata_a), .ram_wdata_b(ram_wdata_b),
    .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
    .ram_rdata_a(ram_rdata_a), .ram_rdata_b(ram_rdata_b)
  );

  // Registered-read RAM; a read issued together with a write returns the old word.
  logic [DW-1:0] mem [1024];
  always @(posedge clk) begin
    ram_rdata_a <= mem[ram_addr_a];
    ram_rdata_b <= mem[ram_addr_b];
    if (ram_we_a) mem[ram_addr_a] <= ram_wdata_a;
    if (ram_we_b) mem[ram_addr_b] <= ram_wdata_b;
  end

  typedef struct {
    int            due;
    int            idx;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          expq[$];
  logic [DW-1:0] ref_mem [1024];
  logic [DW-1:0] last_rd [N];
  logic [N-1:0]  got_rdy;
  int            m_ptr;
  logic          m_run;
  int            cyc;
  int            n_tests, n_fail;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [AW-1:0] addr_of(int i);
    return req_addr[i*AW +: AW];
  endfunction

  task automatic drv(int i, logic we, logic [AW-1:0] a, logic [DW-1:0] d);
    req_valid[i]          = 1'b1;
    req_we[i]             = we;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic idle_in();
    req_valid = '0;
    req_we    = '0;
  endtask

  // Grants straight from the rules: the valid requesters in rotated order,
  // where A is the first entry and B is the first later entry that does not write-collide with A.
  function automatic void pick(output int a, output int b);
    int ord[$];
    a = -1;
    b = -1;
    if (!m_run) return;
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) ord.push_back((m_ptr + k) % N);
    if (ord.size() == 0) return;
    a = ord[0];
    for (int j = 1; j < ord.size(); j++) begin
      if (!(req_we[a] && req_we[ord[j]] && addr_of(a) == addr_of(ord[j]))) begin
        b = ord[j];
        break;
      end
    end
  endfunction

  task automatic check_rsp();
    logic [N-1:0]    ev;
    logic [N*DW-1:0] ed;
    ev = '0;
    for (int j = expq.size() - 1; j >= 0; j--) begin
      if (expq[j].due == cyc) begin
        ev[expq[j].idx]      = 1'b1;
        last_rd[expq[j].idx] = expq[j].data;
        expq.delete(j);
      end
    end
    for (int i = 0; i < N; i++) ed[i*DW +: DW] = last_rd[i];
    chk("rsp_valid", 64'(rsp_valid), 64'(ev));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(ed));
  endtask

  // Applies the inputs that are currently driven for one clock.
  // It checks the grants, and then checks the responses that fall due after the edge.
  task automatic cycle_run();
    int            a, b;
    logic [N-1:0]  er;
    exp_t          e;
    int            w[2];
    #1;
    pick(a, b);
    er = '0;
    if (a >= 0) er[a] = 1'b1;
    if (b >= 0) er[b] = 1'b1;
    got_rdy = req_ready;
    chk("req_ready", 64'(req_ready), 64'(er));
    w[0] = a;
    w[1] = b;
    for (int p = 0; p < 2; p++) begin
      if (w[p] >= 0 && !req_we[w[p]]) begin
        e.due  = cyc + 3;
        e.idx  = w[p];
        e.data = ref_mem[addr_of(w[p])];
        expq.push_back(e);
      end
    end
    for (int p = 0; p < 2; p++)
      if (w[p] >= 0 && req_we[w[p]]) ref_mem[addr_of(w[p])] = req_wdata[w[p]*DW +: DW];
    if (b >= 0) m_ptr = (b + 1) % N;
    else if (a >= 0) m_ptr = (a + 1) % N;
    step();
    check_rsp();
  endtask

  task automatic run_init(string tag);
    int hits[1024];
    int nwr, bad_data, bad_rdy, k, badcov;
    foreach (hits[x]) hits[x] = 0;
    nwr = 0; bad_data = 0; bad_rdy = 0; k = 0; badcov = 0;
    for (int i = 0; i < N; i++) drv(i, 1'b0, AW'(i), '0);
    rst = 1'b0;
    while (!init_done && k < 2000) begin
      step();
      k++;
      if (ram_we_a) begin nwr++; if (ram_wdata_a !== '0) bad_data++; hits[ram_addr_a]++; end
      if (ram_we_b) begin nwr++; if (ram_wdata_b !== '0) bad_data++; hits[ram_addr_b]++; end
      if (!init_done && req_ready !== '0) bad_rdy++;
    end
    idle_in();
    foreach (hits[x]) if (hits[x] != 1) badcov++;
    chk({tag, "_cycles"},   64'(k), 64'd512);
    chk({tag, "_writes"},   64'(nwr), 64'd1024);
    chk({tag, "_coverage"}, 64'(badcov), 64'd0);
    chk({tag, "_zero"},     64'(bad_data), 64'd0);
    chk({tag, "_ready0"},   64'(bad_rdy), 64'd0);
    foreach (ref_mem[x]) ref_mem[x] = '0;
    m_run = 1'b1;
    m_ptr = 0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    m_run = 1'b0; m_ptr = 0;
    foreach (last_rd[i]) last_rd[i] = '0;
    req_addr = '0; req_wdata = '0;
    idle_in();
    rst = 1'b1;
    step();
    for (int i = 0; i < N; i++) drv(i, 1'b0, '0, '0);
    step();
    #1;
    chk("rst_init_done", 64'(init_done), 64'd0);
    chk("rst_ready",     64'(req_ready), 64'd0);
    chk("rst_rsp",       {60'd0, rsp_valid}, 64'd0);
    chk("rst_rdata",     64'(rsp_rdata), 64'd0);
    chk("rst_ram_cmd",   {ram_we_a, ram_we_b, ram_addr_a, ram_addr_b, ram_wdata_a, ram_wdata_b}, 64'd0);

    run_init("init");

    // Write, then read back through another requester.
    drv(0, 1'b1, 10'h005, 16'h1234); cycle_run(); idle_in();
    drv(1, 1'b0, 10'h005, 16'h0000); cycle_run(); idle_in();
    cycle_run();
    cycle_run();
    chk("wr_rd_valid", 64'(rsp_valid[1]), 64'd1);
    chk("wr_rd_data",  64'(rsp_rdata[1*DW +: DW]), 64'h1234);

    // All four requesters read continuously. The pointer sits at 2 after req1's grant.
    for (int i = 0; i < N; i++) drv(i, 1'b0, AW'(16 + i), '0);
    for (int c = 0; c < 8; c++) begin
      cycle_run();
      if (c == 0) chk("pair0", 64'(got_rdy), 64'b1100);
      if (c == 1) chk("pair1", 64'(got_rdy), 64'b0011);
    end
    idle_in();
    repeat (3) cycle_run();

    // Two writes collide on 0x3FF. Only slot A wins, and the loser follows on the next cycle.
    drv(0, 1'b1, 10'h3FF, 16'hAAAA);
    drv(1, 1'b1, 10'h3FF, 16'h5555);
    cycle_run();
    chk("coll_first", 64'(got_rdy), 64'b0001);
    req_valid[0] = 1'b0;
    cycle_run();
    chk("coll_second", 64'(got_rdy), 64'b0010);
    idle_in();
    drv(2, 1'b0, 10'h3FF, '0); cycle_run(); idle_in();
    cycle_run();
    cycle_run();
    chk("coll_final", 64'(rsp_rdata[2*DW +: DW]), 64'h5555);
    chk("coll_ram",   64'(mem[10'h3FF]), 64'h5555);

    // A read and a write to the same address in one cycle. The read sees the old word.
    drv(2, 1'b1, 10'h010, 16'hBEEF);
    drv(3, 1'b0, 10'h010, '0);
    cycle_run();
    chk("rbw_grant", 64'(got_rdy), 64'b1100);
    idle_in();
    cycle_run();
    cycle_run();
    chk("rbw_valid", 64'(rsp_valid[3]), 64'd1);
    chk("rbw_data",  64'(rsp_rdata[3*DW +: DW]), 64'h0000);

    // Randomised traffic over a small address window, so that collisions are frequent.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i]          = ($urandom_range(0, 99) < 65);
        req_we[i]             = 1'($urandom);
        req_addr[i*AW +: AW]  = AW'($urandom_range(0, 11));
        req_wdata[i*DW +: DW] = DW'($urandom);
      end
      cycle_run();
    end
    idle_in();
    repeat (3) cycle_run();

    // Reset while two reads are in flight and a write is registered.
    drv(0, 1'b0, 10'h005, '0);
    drv(1, 1'b0, 10'h3FF, '0);
    cycle_run();
    idle_in();
    drv(2, 1'b1, 10'h020, 16'hA5A5);
    cycle_run();
    idle_in();
    rst = 1'b1;
    step();
    chk("mrst_rsp",      {60'd0, rsp_valid}, 64'd0);
    chk("mrst_wr_done",  64'(mem[10'h020]), 64'hA5A5);
    chk("mrst_init",     64'(init_done), 64'd0);
    step();
    chk("mrst_rsp2",     {60'd0, rsp_valid}, 64'd0);
    chk("mrst_rdata",    64'(rsp_rdata), 64'd0);
    expq.delete();
    foreach (last_rd[i]) last_rd[i] = '0;
    m_run = 1'b0;
    run_init("reinit");
    repeat (3) cycle_run();
    drv(1, 1'b0, 10'h020, '0); cycle_run(); idle_in();
    repeat (2) cycle_run();
    chk("reinit_clear", 64'(rsp_rdata[1*DW +: DW]), 64'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dpram_port_arbiter.md
Name: dpram_port_arbiter

Overview:
Shares the two ports of the 1024x16 dual-port RAM among NUM_REQ requesters using round-robin arbitration, granting up to two requests per cycle (one per RAM port). After reset it runs a clear sequence that zeroes every RAM word using both ports before accepting traffic. It sits between client engines and the RAM macro and owns all RAM port signals.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 10, RAM address width
DATA_W, 16, RAM data width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester grant; handshake = valid & ready at a rising edge
req_we  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_W  flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  flattened write data
rsp_valid  out  NUM_REQ  read data valid for requester i
rsp_rdata  out  NUM_REQ*DATA_W  flattened read data
init_done  out  1  high once clear sequence complete
ram_addr_a, ram_addr_b  out  ADDR_W  RAM port addresses
ram_wdata_a, ram_wdata_b  out  DATA_W  RAM write data
ram_we_a, ram_we_b  out  1  RAM write enables
ram_rdata_a, ram_rdata_b  in  DATA_W  RAM registered read data (valid one cycle after address sampled)

Behaviour:
- Reset: state=INIT, init counter=0, rr pointer=0, init_done=0, req_ready=0, rsp_valid=0, rsp_rdata=0, ram_we_a/b=0, ram_addr_a/b=0, ram_wdata_a/b=0, tag pipeline cleared.
- FSM INIT: each cycle writes 0 to addr {cnt,0} on port A and {cnt,1} on port B; cnt is ADDR_W-1 bits; 2^(ADDR_W-1) cycles (512 at defaults). On cnt wrap -> RUN, init_done=1 from next cycle. req_ready=0 throughout INIT.
- FSM RUN: stays until rst. No other transitions.
- Arbitration (RUN, combinational req_ready): scan requesters starting at rr pointer, wrapping; first valid requester -> port A, second valid -> port B. At most two ready bits high per cycle.
- Write collision: if both winners are writes to the same address, only port A winner granted; port B slot goes to next valid requester whose request does not collide, else idle.
- Read/write same address across ports: both granted; read returns pre-write data (RAM read-before-write). Documented, not prevented.
- rr pointer: after any grant, advances to (last granted index + 1) mod NUM_REQ; unchanged if no grant.
- RAM command registered: accepted requests drive ram_* on the edge of the handshake; idle port drives we=0, address held.
- Read latency: handshake at edge E0 -> ram_* registered at E0 -> RAM samples at E1 -> rsp_valid[i] high during the cycle after E2 (registered at E2), rsp_rdata slice i registered with it. Fixed 2-cycle latency, fully pipelined, one read per requester per cycle max. Writes produce no response.
- Tag pipeline: 2 stages, per port {valid, read, requester index}.
- rsp_rdata slice holds last value when rsp_valid low.
- rst mid-operation: in-flight reads dropped (rsp_valid=0 next cycle), any RAM write registered before the rst edge still completes, clear sequence restarts from 0.

Decomposition:
- Package dpram_arb_pkg: state enum (INIT, RUN), localparams for clog2(NUM_REQ) index width and tag struct {vld, rd, idx}.
- Sub-module rr_pick2: combinational two-winner round-robin picker with collision mask input; instantiated once.

Test Plan:
- Reset then idle -> init_done rises exactly 512 cycles after rst deasserts; RAM observed with 1024 writes of 0x0000, addrs 0..1023 each once; req_ready=0 throughout.
- Req0 writes 0x1234 to 0x005, then req1 reads 0x005 -> rsp_valid[1] high 2 cycles after read handshake, rsp_rdata[1]=0x1234.
- All four requesters hold valid reads continuously -> grants pairs {0,1},{2,3},{0,1}...; each requester gets one response every 2 cycles.
- Req0 and req1 both write addr 0x3FF in same cycle -> only req0 granted; req1 granted next cycle; final RAM word = req1 data.
- Req2 writes 0xBEEF to 0x010 while req3 reads 0x010 in same cycle -> both granted; rsp_rdata[3]=prior value (0x0000 after init).
- Assert rst with two reads in flight -> no rsp_valid after rst; init_done=0, clear restarts, init_done rises 512 cycles later.
